// File: rtl/multi_clock_checkout_pkg.sv
// Shared types for the multi-clock checkout block: FSM state encoding and
// the channel-index width helper used by the result stream.
package multi_clock_checkout_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        GATE  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    function automatic int user_width(input int nchan);
        return (nchan > 1) ? $clog2(nchan) : 1;
    endfunction

endpackage

// File: rtl/multi_clock_checkout_sync.sv
// Synchroniser chain for one asynchronous toggle input plus an edge detector
// that fires once for every rising or falling transition.
module toggle_edge_sync #(
    parameter int SYNC_STAGES = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
        end
    end

    assign edge_o = sync_q[SYNC_STAGES-1] ^ sync_q[SYNC_STAGES-2];

endmodule

// File: rtl/multi_clock_checkout.sv
// Counts edges of NCHAN divided test-clock toggles over a gate window of clk_i
// cycles and streams the per-channel {overflow, count} results out in order.
module multi_clock_checkout
    import multi_clock_checkout_pkg::*;
#(
    parameter int NCHAN       = 4,
    parameter int CNT_WIDTH   = 24,
    parameter int GATE_WIDTH  = 17,
    parameter int SYNC_STAGES = 3
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NCHAN-1:0]                toggle_i,
    input  logic [GATE_WIDTH-1:0]           gate_len_i,
    input  logic                            start_i,
    input  logic                            continuous_i,
    output logic                            busy_o,
    output logic [CNT_WIDTH:0]              m_tdata,
    output logic [user_width(NCHAN)-1:0]    m_tuser,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic                            m_tlast,
    output logic [1:0]                      dbg_state_o
);

    localparam int                   UW      = user_width(NCHAN);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [UW-1:0]        LAST_CH = UW'(NCHAN - 1);

    state_e                state_q;
    logic [GATE_WIDTH-1:0] gate_cnt_q;
    logic [CNT_WIDTH-1:0]  cnt_q [NCHAN];
    logic [CNT_WIDTH-1:0]  cnt_d [NCHAN];
    logic [NCHAN-1:0]      ovf_q;
    logic [NCHAN-1:0]      ovf_d;
    logic [CNT_WIDTH:0]    res_q [NCHAN];
    logic [UW-1:0]         beat_q;
    logic [UW-1:0]         beat_nx;
    logic [NCHAN-1:0]      edge_w;

    genvar g;
    generate
        for (g = 0; g < NCHAN; g++) begin : g_sync
            toggle_edge_sync #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_sync (
                .clk_i  (clk_i),
                .rst_i  (rst_i),
                .async_i(toggle_i[g]),
                .edge_o (edge_w[g])
            );
        end
    endgenerate

    // Next counts include the edge of the current cycle so the final GATE
    // cycle is captured into the result bank without a one-cycle loss.
    always_comb begin
        for (int i = 0; i < NCHAN; i++) begin
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = ovf_q[i];
            if (state_q == GATE && edge_w[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign beat_nx     = beat_q + UW'(1);
    assign dbg_state_o = state_q;

    // Stream handshake: a beat transfers on a cycle with m_tvalid & m_tready;
    // while m_tvalid=1 and m_tready=0 the beat (data, user, last) is frozen.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            gate_cnt_q <= '0;
            ovf_q      <= '0;
            beat_q     <= '0;
            busy_o     <= 1'b0;
            m_tvalid   <= 1'b0;
            m_tlast    <= 1'b0;
            m_tdata    <= '0;
            m_tuser    <= '0;
            for (int i = 0; i < NCHAN; i++) begin
                cnt_q[i] <= '0;
                res_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= ARM;
                        busy_o  <= 1'b1;
                    end
                end
                ARM: begin
                    for (int i = 0; i < NCHAN; i++) begin
                        cnt_q[i] <= '0;
                    end
                    ovf_q      <= '0;
                    gate_cnt_q <= (gate_len_i == '0) ? GATE_WIDTH'(1) : gate_len_i;
                    state_q    <= GATE;
                end
                GATE: begin
                    for (int i = 0; i < NCHAN; i++) begin
                        cnt_q[i] <= cnt_d[i];
                    end
                    ovf_q      <= ovf_d;
                    gate_cnt_q <= gate_cnt_q - GATE_WIDTH'(1);
                    if (gate_cnt_q == GATE_WIDTH'(1)) begin
                        for (int i = 0; i < NCHAN; i++) begin
                            res_q[i] <= {ovf_d[i], cnt_d[i]};
                        end
                        state_q  <= DRAIN;
                        m_tvalid <= 1'b1;
                        m_tdata  <= {ovf_d[0], cnt_d[0]};
                        m_tuser  <= '0;
                        m_tlast  <= (LAST_CH == '0);
                        beat_q   <= '0;
                    end
                end
                DRAIN: begin
                    if (m_tready) begin
                        if (beat_q == LAST_CH) begin
                            m_tvalid <= 1'b0;
                            m_tlast  <= 1'b0;
                            m_tdata  <= '0;
                            m_tuser  <= '0;
                            if (continuous_i) begin
                                state_q <= ARM;
                            end else begin
                                state_q <= IDLE;
                                busy_o  <= 1'b0;
                            end
                        end else begin
                            beat_q  <= beat_nx;
                            m_tdata <= res_q[beat_nx];
                            m_tuser <= beat_nx;
                            m_tlast <= (beat_nx == LAST_CH);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_clock_checkout.sv
// Scoreboard bench for multi_clock_checkout: a negedge monitor models the gate
// window from the toggles it observes and checks every streamed beat.
module tb_multi_clock_checkout;
    import multi_clock_checkout_pkg::*;

    localparam int NCHAN       = 4;
    localparam int CNT_WIDTH   = 8;
    localparam int GATE_WIDTH  = 17;
    localparam int SYNC_STAGES = 3;
    localparam int UW          = 2;
    localparam int W           = 1 + UW + CNT_WIDTH + 1;
    localparam int MAXC        = 40000;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NCHAN-1:0]      toggle;
    logic [GATE_WIDTH-1:0] gate_len;
    logic                  start;
    logic                  cont;
    logic                  busy;
    logic [CNT_WIDTH:0]    tdata;
    logic [UW-1:0]         tuser;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [1:0]            dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    int  tog_period [NCHAN];
    bit  tog_rand   = 0;
    bit  gl_rand    = 0;
    int  ready_mode = 0;
    int  stall_cnt  = 0;
    int  drv_cyc    = 0;
    int  burst_cnt  = 0;
    int  valid_cycles = 0;
    logic [CNT_WIDTH:0] got_last [NCHAN];

    always #5 clk = ~clk;

    multi_clock_checkout #(
        .NCHAN      (NCHAN),
        .CNT_WIDTH  (CNT_WIDTH),
        .GATE_WIDTH (GATE_WIDTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .toggle_i    (toggle),
        .gate_len_i  (gate_len),
        .start_i     (start),
        .continuous_i(cont),
        .busy_o      (busy),
        .m_tdata     (tdata),
        .m_tuser     (tuser),
        .m_tvalid    (tvalid),
        .m_tready    (tready),
        .m_tlast     (tlast),
        .dbg_state_o (dbg_state)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- drivers (all change 2 time units after the edge)
    initial begin
        toggle = '0;
        forever begin
            @(posedge clk);
            #2;
            drv_cyc++;
            for (int ch = 0; ch < NCHAN; ch++) begin
                if (tog_rand) begin
                    if ($urandom_range(0, 3) == 0) toggle[ch] = ~toggle[ch];
                end else if (tog_period[ch] != 0 && (drv_cyc % tog_period[ch]) == 0) begin
                    toggle[ch] = ~toggle[ch];
                end
            end
        end
    end

    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                1: tready = 1'($urandom_range(0, 1));
                2: begin
                    if (tvalid && tuser == 2'd2 && stall_cnt < 5) begin
                        tready = 1'b0;
                        stall_cnt++;
                    end else begin
                        tready = 1'b1;
                    end
                end
                default: tready = 1'b1;
            endcase
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (gl_rand && $urandom_range(0, 7) == 0) gate_len = GATE_WIDTH'($urandom_range(0, 200));
        end
    end

    // ---------------- monitor / scoreboard
    initial begin
        int        mc;
        logic [NCHAN-1:0] flips [MAXC];
        logic [NCHAN-1:0] prev_tog;
        state_e    st, prev_st;
        int        gate_start, exp_len, n;
        bit        start_prev, last_hs, cont_at_last, prev_valid, prev_ready;
        logic [W-1:0] cur, prev_beat, e;
        logic [CNT_WIDTH:0] d;
        mc = 0; gate_start = 0; exp_len = 0;
        prev_st = IDLE; prev_tog = '0; start_prev = 0; last_hs = 0;
        cont_at_last = 0; prev_valid = 0; prev_ready = 0; prev_beat = '0;
        forever begin
            @(negedge clk);
            mc++;
            if (mc >= MAXC) begin
                $display("FAIL cycle_budget: got %0d expected below %0d", mc, MAXC);
                $fatal(1, "cycle budget exhausted");
            end
            if (rst) begin
                flips[mc] = '0; prev_tog = '0; prev_st = IDLE; exp_q.delete();
                prev_valid = 0; last_hs = 0; start_prev = 0;
            end else begin
                flips[mc] = toggle ^ prev_tog;
                prev_tog  = toggle;
                st  = state_e'(dbg_state);
                cur = {tlast, tuser, tdata};
                if (last_hs)                check("drain_exit", 32'(st), 32'(cont_at_last ? ARM : IDLE));
                else if (prev_st == IDLE)   check("idle_next", 32'(st), 32'(start_prev ? ARM : IDLE));
                else if (prev_st == ARM)    check("arm_one_cycle", 32'(st), 32'(GATE));
                else if (prev_st == DRAIN)  check("drain_hold", 32'(st), 32'(DRAIN));
                if (st == ARM) exp_len = (gate_len == '0) ? 1 : int'(gate_len);
                if (st == GATE && prev_st != GATE) gate_start = mc;
                if (prev_st == GATE && st != GATE) begin
                    check("gate_len", 32'(mc - gate_start), 32'(exp_len));
                    check("gate_exit", 32'(st), 32'(DRAIN));
                    for (int ch = 0; ch < NCHAN; ch++) begin
                        n = 0;
                        for (int gc = gate_start; gc < mc; gc++) n += int'(flips[gc-2][ch]);
                        d = (n > 255) ? 9'h1FF : {1'b0, 8'(n)};
                        e = {(ch == NCHAN - 1) ? 1'b1 : 1'b0, UW'(ch), d};
                        exp_q.push_back(e);
                    end
                end
                if (prev_valid && !prev_ready) begin
                    check("hold_valid", 32'(tvalid), 32'd1);
                    check("hold_beat", 32'(cur), 32'(prev_beat));
                end
                last_hs = 0;
                if (tvalid) valid_cycles++;
                if (tvalid && tready) begin
                    if (exp_q.size() == 0) begin
                        check("beat_unexpected", 32'(cur), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", 32'(cur), 32'(e));
                    end
                    got_last[tuser] = tdata;
                    if (tlast) begin
                        last_hs = 1; cont_at_last = cont; burst_cnt++;
                    end
                end
                prev_valid = tvalid; prev_ready = tready; prev_beat = cur;
                start_prev = start; prev_st = st;
            end
        end
    end

    // ---------------- stimulus tasks
    task automatic start_pulse();
        @(posedge clk); #2; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
        @(posedge clk); #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_tvalid"}, 32'(tvalid), 32'd0);
        check({tag, "_tlast"}, 32'(tlast), 32'd0);
        check({tag, "_tdata"}, 32'(tdata), 32'd0);
        check({tag, "_tuser"}, 32'(tuser), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        int b0, vc0, k;
        rst = 1'b1; start = 1'b0; cont = 1'b0; gate_len = '0;
        for (int ch = 0; ch < NCHAN; ch++) tog_period[ch] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #2; rst = 1'b0;
        repeat (5) @(posedge clk); #2;

        // One burst, ch0 toggling every 5 cycles; a stray start mid-GATE is ignored
        gate_len = 17'd1000; tog_period[0] = 5;
        start_pulse();
        repeat (100) @(posedge clk); #2;
        start_pulse();
        wait_idle(3000);
        check("t1_ch0_range", 32'(got_last[0] >= 9'd199 && got_last[0] <= 9'd201), 32'd1);
        for (int ch = 1; ch < NCHAN; ch++) check("t1_idle_ch", 32'(got_last[ch]), 32'd0);
        tog_period[0] = 0;

        // Saturation: ch1 flips every 2 cycles -> 500 edges on an 8-bit counter
        tog_period[1] = 2;
        start_pulse();
        wait_idle(3000);
        check("t2_ch1_sat", 32'(got_last[1]), 32'h1FF);
        tog_period[1] = 0;

        // Backpressure: beat 2 stalled for 5 cycles
        gate_len = 17'd200; tog_period[2] = 3; stall_cnt = 0; ready_mode = 2;
        start_pulse();
        wait_idle(2000);
        check("t3_stall_cycles", 32'(stall_cnt), 32'd5);
        ready_mode = 0; tog_period[2] = 0;

        // Continuous mode: back-to-back bursts with busy held high
        gate_len = 17'd100; cont = 1'b1; tog_period[0] = 3; tog_period[3] = 7;
        b0 = burst_cnt;
        start_pulse();
        k = 0;
        while (burst_cnt < b0 + 3 && k < 2000) begin
            @(negedge clk);
            check("t4_busy", 32'(busy), 32'd1);
            k++;
        end
        check("t4_bursts", 32'(burst_cnt >= b0 + 3), 32'd1);
        @(posedge clk); #2; cont = 1'b0;
        wait_idle(2000);
        tog_period[0] = 0; tog_period[3] = 0;

        // Reset at gate cycle 50: nothing emitted, then a clean full window
        gate_len = 17'd1000; tog_period[3] = 4;
        vc0 = valid_cycles;
        start_pulse();
        repeat (50) @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midgate_rst");
        @(posedge clk); #2; rst = 1'b0;
        repeat (50) @(posedge clk); #2;
        check("t5_no_valid", 32'(valid_cycles), 32'(vc0));
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
        start_pulse();
        wait_idle(3000);
        check("t5_ch3_range", 32'(got_last[3] >= 9'd249 && got_last[3] <= 9'd251), 32'd1);
        tog_period[3] = 0;

        // gate_len 0 behaves as a single-cycle gate
        gate_len = '0; tog_period[2] = 1;
        start_pulse();
        wait_idle(200);
        check("t6_ch2_le1", 32'(got_last[2] <= 9'd1), 32'd1);
        tog_period[2] = 0;

        // Random toggles, random ready, gate length changing under the FSM
        tog_rand = 1; ready_mode = 1;
        for (int i = 0; i < 8; i++) begin
            gate_len = GATE_WIDTH'($urandom_range(0, 300));
            gl_rand = 1;
            start_pulse();
            wait_idle(3000);
            gl_rand = 0;
        end
        tog_rand = 0; ready_mode = 0;

        repeat (10) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_clock_checkout.md
MULTI_CLOCK_CHECKOUT -- requirements
Module: multi_clock_checkout

Interface
REQ-001 SHALL have parameter NCHAN, default 4, meaning the number of monitored toggle inputs (1..16).
REQ-002 SHALL have parameter CNT_WIDTH, default 24, meaning the per-channel edge counter width.
REQ-003 SHALL have parameter GATE_WIDTH, default 17, meaning the gate-length width in clk_i cycles.
REQ-004 SHALL have parameter SYNC_STAGES, default 3, meaning the synchroniser depth (min 2).
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all logic is clocked by it.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port toggle_i, input, NCHAN bits: divided test-clock toggles, asynchronous to clk_i.
REQ-008 SHALL have port gate_len_i, input, GATE_WIDTH bits: measurement window in clk_i cycles.
REQ-009 SHALL have port start_i, input, 1 bit: single-cycle measurement request.
REQ-010 SHALL have port continuous_i, input, 1 bit: when 1, re-arm automatically after each drain.
REQ-011 SHALL have port busy_o, output, 1 bit: high in any state other than IDLE.
REQ-012 SHALL have port m_tdata, output, CNT_WIDTH+1 bits: {overflow, count} for one channel.
REQ-013 SHALL have port m_tuser, output, $clog2(NCHAN) bits (min 1): channel index of the beat.
REQ-014 SHALL have ports m_tvalid (output), m_tready (input) and m_tlast (output), 1 bit each: result stream handshake.

Function
REQ-015 SHALL pass each toggle_i bit through a SYNC_STAGES flop chain; an edge is last-stage XOR previous-stage, so rising and falling transitions each count once.
REQ-016 SHALL implement FSM IDLE -> ARM -> GATE -> DRAIN -> (ARM if continuous_i else IDLE).
REQ-017 IDLE -> ARM SHALL occur on start_i=1; start_i SHALL be ignored in every other state.
REQ-018 ARM SHALL last exactly 1 cycle: clear all counters and overflow flags; load gate counter with gate_len_i, or with 1 if gate_len_i==0.
REQ-019 GATE SHALL last exactly the loaded number of cycles; a synchronised edge is counted only in cycles spent in GATE.
REQ-020 Counters SHALL saturate at 2^CNT_WIDTH-1; an edge at saturation SHALL set that channel's sticky overflow flag.
REQ-021 On leaving GATE, all counts and overflow flags SHALL be captured in the same cycle into a result bank.
REQ-022 In DRAIN the block SHALL emit NCHAN beats in channel order 0..NCHAN-1, with m_tlast on channel NCHAN-1.
REQ-023 A beat SHALL complete only on m_tvalid & m_tready; m_tdata, m_tuser and m_tlast SHALL hold stable while m_tvalid=1 and m_tready=0.
REQ-024 m_tvalid SHALL be 1 only in DRAIN; the cycle after the last beat completes, the FSM SHALL leave DRAIN.
REQ-025 continuous_i SHALL be sampled at the cycle the last beat completes.
REQ-026 gate_len_i changes SHALL take effect only at the next ARM.

Reset
REQ-027 Asserting rst_i at any time, including mid-GATE or mid-DRAIN, SHALL immediately force: state IDLE, busy_o=0, m_tvalid=0, m_tlast=0, m_tdata=0, m_tuser=0, counters, flags, result bank and synchroniser flops all 0.
REQ-028 After rst_i deasserts, the block SHALL wait in IDLE for start_i; no partial result SHALL ever be emitted.

Structure
REQ-029 SHALL place the state enum (IDLE, ARM, GATE, DRAIN) in package multi_clock_checkout_pkg.
REQ-030 SHALL use one sub-module, toggle_edge_sync (synchroniser plus edge detect, parameter SYNC_STAGES), instantiated NCHAN times in a generate loop.

Verification
REQ-031 Setup NCHAN=4, gate_len_i=1000, toggle_i[0] flipping every 5 cycles, start_i pulse -> one 4-beat burst; ch0 count 200 ±1, overflow 0; idle channels 0; m_tlast on ch3.
REQ-032 Setup CNT_WIDTH=8, gate_len_i=1000, toggle_i[1] flipping every 2 cycles -> ch1 m_tdata = {1, 255}.
REQ-033 Hold m_tready=0 for 5 cycles on beat 2 -> m_tdata/m_tuser stable throughout; beats stay in order with no loss or duplication.
REQ-034 continuous_i=1 with gate_len_i=100 -> back-to-back bursts, each preceded by exactly one ARM cycle; busy_o stays 1.
REQ-035 rst_i pulse at gate cycle 50 -> m_tvalid never rises; a new start_i gives a clean full-window result.
REQ-036 gate_len_i=0 with a toggle every cycle -> GATE lasts exactly 1 cycle; count 0 or 1.
